mha_matmul_scheduler: RTL and testbench

- Sequencer that time-shares one multi_matmul_wrapper instance (the Qn·KnT matmul) between NUM_HEADS ping-pong bridge buffer instances.
- Sits between the per-head ping-pong banks and the shared matmul.
- Arbitrates ready heads round-robin and drives the head-select mux.
- Sequences the matmul's internal reset, enable and accumulator reset; returns a release pulse to the served head so that head can swap banks.

---
 rtl/mha_matmul_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_mha_matmul_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mha_matmul_scheduler.sv
// rtl/mha_matmul_scheduler.sv - round-robin time-sharing sequencer for one shared Qn*KnT matmul
//
// Purpose: arbitrates NUM_HEADS ping-pong bridge buffers onto a single
// multi_matmul_wrapper instance. It drives the head-select mux and sequences
// the matmul reset/enable/accumulator clear. It also pulses a release back to
// the served head so that head can swap banks.
//
// Ports:
//   clk                     clock
//   rst_n                   synchronous active-low reset
//   head_ready              per-head level: bank full, ready to be consumed
//   acc_done_wrap           matmul pulse: one output block accumulated
//   systolic_finish_wrap    matmul pulse: whole tile finished
//   sel_head                index of the head routed to the matmul inputs
//   head_release            one-hot 1-cycle pulse: served head's bank consumed
//   internal_rst_n_ctrl     active-low reset to the matmul
//   internal_reset_acc_ctrl accumulator clear to the matmul
//   enable_matmul           matmul enable
//   out_valid               result word valid on the matmul output
//   busy                    high whenever the sequencer is not idle
//   err_timeout             sticky: a tile ran TIMEOUT cycles without finishing
module mha_matmul_scheduler #(
    parameter int NUM_HEADS  = 4,
    parameter int HEAD_W     = $clog2(NUM_HEADS),
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_HEADS-1:0] head_ready,
    input  logic                 acc_done_wrap,
    input  logic                 systolic_finish_wrap,
    output logic [HEAD_W-1:0]    sel_head,
    output logic [NUM_HEADS-1:0] head_release,
    output logic                 internal_rst_n_ctrl,
    output logic                 internal_reset_acc_ctrl,
    output logic                 enable_matmul,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int RCNT_W = $clog2(RST_CYCLES + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_MRST,
        S_RUN,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [HEAD_W-1:0]   ptr_q, ptr_d;
    logic [HEAD_W-1:0]   sel_q, sel_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                err_q, err_d;
    logic [NUM_HEADS-1:0] rel_q, rel_d;
    logic                rst_ctrl_q, rst_ctrl_d;
    logic                racc_q, racc_d;
    logic                en_q, en_d;
    logic                ov_q, ov_d;
    logic                busy_q, busy_d;

    logic                found;
    logic [HEAD_W-1:0]   pick;
    logic [HEAD_W:0]     cand;
    logic [HEAD_W:0]     ptr_nxt;
    logic [NUM_HEADS-1:0] sel_oh;

    assign sel_oh = NUM_HEADS'(1) << sel_q;

    // Round-robin search: first ready head at or above the pointer, wrapping.
    // cand is one bit wider so pointer + offset never overflows before the wrap.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int i = 0; i < NUM_HEADS; i++) begin
            cand = {1'b0, ptr_q} + (HEAD_W + 1)'(i);
            if (cand >= (HEAD_W + 1)'(NUM_HEADS)) begin
                cand = cand - (HEAD_W + 1)'(NUM_HEADS);
            end
            if (!found && head_ready[cand[HEAD_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[HEAD_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_nxt = {1'b0, pick} + (HEAD_W + 1)'(1);
        if (ptr_nxt == (HEAD_W + 1)'(NUM_HEADS)) begin
            ptr_nxt = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        rcnt_d  = rcnt_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (|head_ready) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Ready may have dropped since IDLE saw it; fall back without a grant.
                if (found) begin
                    sel_d   = pick;
                    ptr_d   = ptr_nxt[HEAD_W-1:0];
                    rcnt_d  = '0;
                    state_d = S_MRST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MRST: begin
                if (rcnt_q == RCNT_W'(RST_CYCLES - 1)) begin
                    tcnt_d  = '0;
                    state_d = S_RUN;
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
            end
            S_RUN: begin
                tcnt_d = tcnt_q + TCNT_W'(1);
                if (systolic_finish_wrap) begin
                    state_d = S_RELEASE;
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // The released head is mid bank-swap, so its own ready bit
                // must not trigger another grant this cycle.
                if (|(head_ready & ~sel_oh)) begin
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe. Accumulator events are delayed exactly one cycle,
    // which lets a pulse coincident with finish land in RELEASE.
    always_comb begin
        rst_ctrl_d = (state_d != S_MRST);
        en_d       = (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);
        rel_d      = (state_d == S_RELEASE) ? (NUM_HEADS'(1) << sel_d) : '0;
        ov_d       = (state_q == S_RUN) && acc_done_wrap;
        racc_d     = (state_q == S_RUN) && acc_done_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            rcnt_q     <= '0;
            tcnt_q     <= '0;
            err_q      <= 1'b0;
            rel_q      <= '0;
            rst_ctrl_q <= 1'b0;
            racc_q     <= 1'b0;
            en_q       <= 1'b0;
            ov_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            rcnt_q     <= rcnt_d;
            tcnt_q     <= tcnt_d;
            err_q      <= err_d;
            rel_q      <= rel_d;
            rst_ctrl_q <= rst_ctrl_d;
            racc_q     <= racc_d;
            en_q       <= en_d;
            ov_q       <= ov_d;
            busy_q     <= busy_d;
        end
    end

    assign sel_head                = sel_q;
    assign head_release            = rel_q;
    assign internal_rst_n_ctrl     = rst_ctrl_q;
    assign internal_reset_acc_ctrl = racc_q;
    assign enable_matmul           = en_q;
    assign out_valid               = ov_q;
    assign busy                    = busy_q;
    assign err_timeout             = err_q;

endmodule

// File: tb/tb_mha_matmul_scheduler.sv
// tb/tb_mha_matmul_scheduler.sv - self-checking bench for mha_matmul_scheduler
module tb_mha_matmul_scheduler;

    localparam int NH  = 4;
    localparam int RST = 2;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NH-1:0] head_ready;
    logic          acc_done_wrap;
    logic          systolic_finish_wrap;
    logic [1:0]    sel_head;
    logic [NH-1:0] head_release;
    logic          internal_rst_n_ctrl;
    logic          internal_reset_acc_ctrl;
    logic          enable_matmul;
    logic          out_valid;
    logic          busy;
    logic          err_timeout;

    mha_matmul_scheduler #(
        .NUM_HEADS (NH),
        .HEAD_W    (2),
        .RST_CYCLES(RST),
        .TIMEOUT   (TO)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .head_ready             (head_ready),
        .acc_done_wrap          (acc_done_wrap),
        .systolic_finish_wrap   (systolic_finish_wrap),
        .sel_head               (sel_head),
        .head_release           (head_release),
        .internal_rst_n_ctrl    (internal_rst_n_ctrl),
        .internal_reset_acc_ctrl(internal_reset_acc_ctrl),
        .enable_matmul          (enable_matmul),
        .out_valid              (out_valid),
        .busy                   (busy),
        .err_timeout            (err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: arbitration pointer, sticky error, last served head.
    int m_ptr  = 0;
    bit m_err  = 1'b0;
    int m_last = 0;
    bit m_in_grant = 1'b0;

    typedef struct {
        logic [NH-1:0] ready;
        int            exp_head;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NH-1:0] r, input int p);
        for (int o = 0; o < NH; o++) begin
            if (r[(p + o) % NH]) return (p + o) % NH;
        end
        return -1;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        head_ready = '0;
        acc_done_wrap = 1'b0;
        systolic_finish_wrap = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        m_ptr = 0;
        m_err = 1'b0;
        m_in_grant = 1'b0;
    endtask

    task automatic start_from_idle(input logic [NH-1:0] r);
        head_ready = r;
        tick;
    endtask

    // Entered while the DUT is in GRANT; leaves it in the RELEASE cycle.
    // len RUN cycles; without fin the run must end by timeout (len = TO).
    task automatic session(input int len, input logic [15:0] mask, input bit fin,
                           input bit rnd, output int got);
        int  e;
        logic prev;
        e = pick(head_ready, m_ptr);
        chk("grant_busy", 32'(busy), 1);
        chk("grant_rstctl", 32'(internal_rst_n_ctrl), 1);
        chk("grant_en", 32'(enable_matmul), 0);
        m_ptr  = (e + 1) % NH;
        m_last = e;
        tick;
        got = int'(sel_head);
        for (int i = 0; i < RST; i++) begin
            chk("mrst_rstctl", 32'(internal_rst_n_ctrl), 0);
            chk("mrst_en", 32'(enable_matmul), 0);
            chk("mrst_sel", 32'(sel_head), 32'(e));
            if (rnd) head_ready = NH'($urandom);
            tick;
        end
        prev = 1'b0;
        for (int j = 0; j < len; j++) begin
            chk("run_en", 32'(enable_matmul), 1);
            chk("run_rstctl", 32'(internal_rst_n_ctrl), 1);
            chk("run_sel", 32'(sel_head), 32'(e));
            chk("run_ov", 32'(out_valid), 32'(prev));
            chk("run_racc", 32'(internal_reset_acc_ctrl), 32'(prev));
            chk("run_rel", 32'(head_release), 0);
            chk("run_err", 32'(err_timeout), 32'(m_err));
            acc_done_wrap = mask[j];
            systolic_finish_wrap = fin && (j == len - 1);
            if (rnd) head_ready = NH'($urandom);
            tick;
            prev = mask[j];
        end
        acc_done_wrap = 1'b0;
        systolic_finish_wrap = 1'b0;
        if (!fin) m_err = 1'b1;
        chk("rel_en", 32'(enable_matmul), 0);
        chk("rel_pulse", 32'(head_release), 32'(1) << e);
        chk("rel_ov", 32'(out_valid), 32'(prev));
        chk("rel_racc", 32'(internal_reset_acc_ctrl), 32'(prev));
        chk("rel_err", 32'(err_timeout), 32'(m_err));
        chk("rel_busy", 32'(busy), 1);
    endtask

    task automatic after_release(input logic [NH-1:0] r);
        logic [NH-1:0] other;
        head_ready = r;
        other = r & ~(NH'(1) << m_last);
        m_in_grant = (other != '0);
        tick;
        chk("after_busy", 32'(busy), 32'(m_in_grant));
        chk("after_rel", 32'(head_release), 0);
        chk("after_en", 32'(enable_matmul), 0);
        chk("after_ov", 32'(out_valid), 0);
    endtask

    initial begin
        int got;
        int len;
        bit fin;

        tv[0] = '{4'b0001, 0};
        tv[1] = '{4'b0010, 1};
        tv[2] = '{4'b0100, 2};
        tv[3] = '{4'b0101, 0};
        tv[4] = '{4'b0101, 2};
        tv[5] = '{4'b1000, 3};
        tv[6] = '{4'b1111, 0};
        tv[7] = '{4'b1111, 1};

        rst_n = 1'b0;
        head_ready = '0;
        acc_done_wrap = 1'b0;
        systolic_finish_wrap = 1'b0;
        tick;
        tick;
        chk("rst_sel", 32'(sel_head), 0);
        chk("rst_rel", 32'(head_release), 0);
        chk("rst_rstctl", 32'(internal_rst_n_ctrl), 0);
        chk("rst_racc", 32'(internal_reset_acc_ctrl), 0);
        chk("rst_en", 32'(enable_matmul), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        rst_n = 1'b1;
        acc_done_wrap = 1'b1;
        tick;
        acc_done_wrap = 1'b0;
        chk("idle_rstctl", 32'(internal_rst_n_ctrl), 1);
        chk("idle_acc_ignored", 32'(out_valid), 0);
        chk("idle_busy", 32'(busy), 0);

        // Table: single heads, skip-and-wrap, pointer progression from reset.
        for (int k = 0; k < 8; k++) begin
            start_from_idle(tv[k].ready);
            session(2, 16'h0, 1'b1, 1'b0, got);
            chk("tbl_head", 32'(got), 32'(tv[k].exp_head));
            after_release('0);
        end

        // Ready drops before GRANT samples it: no grant, back to idle.
        start_from_idle(4'b0001);
        head_ready = '0;
        tick;
        chk("nogrant_busy", 32'(busy), 0);
        chk("nogrant_sel", 32'(sel_head), 1);
        chk("nogrant_rstctl", 32'(internal_rst_n_ctrl), 1);

        // Round robin with all heads held ready.
        do_reset();
        start_from_idle(4'b1111);
        for (int k = 0; k < 5; k++) begin
            session(3, 16'h0, 1'b1, 1'b0, got);
            chk("rr_head", 32'(got), 32'(k % NH));
            after_release(k < 4 ? 4'b1111 : 4'b0000);
        end

        // Three accumulations, two back-to-back, last coincident with finish.
        start_from_idle(4'b0001);
        session(6, 16'b100011, 1'b1, 1'b0, got);
        after_release('0);

        // Timeout, then a normal grant with the error still sticky.
        start_from_idle(4'b0100);
        session(TO, 16'h0, 1'b0, 1'b0, got);
        after_release(4'b1000);
        session(2, 16'h1, 1'b1, 1'b0, got);
        chk("post_to_head", 32'(got), 3);
        after_release('0);

        // Reset in the middle of RUN while serving head 1 (pointer then at 2).
        start_from_idle(4'b0010);
        chk("mid_grant_busy", 32'(busy), 1);
        for (int i = 0; i < RST + 1; i++) tick;
        chk("mid_run_en", 32'(enable_matmul), 1);
        chk("mid_run_sel", 32'(sel_head), 1);
        rst_n = 1'b0;
        tick;
        chk("midrst_en", 32'(enable_matmul), 0);
        chk("midrst_rstctl", 32'(internal_rst_n_ctrl), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(err_timeout), 0);
        chk("midrst_sel", 32'(sel_head), 0);
        m_ptr = 0;
        m_err = 1'b0;
        rst_n = 1'b1;
        head_ready = 4'b0101;
        tick;
        session(2, 16'h0, 1'b1, 1'b0, got);
        chk("ptr_restart_head", 32'(got), 0);
        after_release('0);
        start_from_idle(4'b0010);
        session(1, 16'h0, 1'b1, 1'b0, got);
        chk("after_rst_head1", 32'(got), 1);
        after_release('0);

        // Randomized traffic against the model.
        m_in_grant = 1'b0;
        for (int it = 0; it < 40; it++) begin
            if (!m_in_grant) start_from_idle(NH'($urandom_range(1, 15)));
            fin = ($urandom_range(0, 3) != 0);
            len = fin ? $urandom_range(1, TO) : TO;
            session(len, 16'($urandom), fin, 1'b1, got);
            after_release(NH'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
